cae_pll_ctl: RTL

CAE_PLL_CTL -- requirements
Module: cae_pll_ctl

---
 rtl/cae_pll_ctl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cae_pll_ctl.sv
// cae_pll_ctl -- PLL reset / lock supervisor.
//
// Drives the PLL reset, waits for lock, and requires lock to stay stable
// for a number of cycles before declaring the clock ready. A lock timeout
// triggers a fresh reset attempt, up to MAX_RETRIES re-attempts, after
// which the controller parks in FAIL until i_reset.
//
// Optional feature (macro CAE_PLL_CTL_AUTORELOCK_EN):
//   defined   -> loss of lock while ready restarts the reset sequence
//   undefined -> loss of lock while ready goes to FAIL
//
// Ports:
//   clk          sole clock, rising edge
//   i_reset      synchronous active-high reset
//   ppll_locked  PLL lock indication, asynchronous to clk (synchronized here)
//   ppll_reset   PLL reset request, active-high (registered)
//   pll_ready    PLL locked and stable (registered)
//   pll_fail     all lock attempts exhausted (registered)
//   lock_lost    sticky: lock dropped while ready (registered)
//   retry_cnt    lock timeouts in the current sequence, saturating
//   dbg_state_o  current FSM state: 0 RST, 1 WAIT_LOCK, 2 STABLE, 3 READY, 4 FAIL
//
// There is no valid/ready handshake on this block: all inputs are levels.
module cae_pll_ctl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 64,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic       clk,
  input  logic       i_reset,
  input  logic       ppll_locked,
  output logic       ppll_reset,
  output logic       pll_ready,
  output logic       pll_fail,
  output logic       lock_lost,
  output logic [3:0] retry_cnt,
  output logic [2:0] dbg_state_o
);

  localparam logic [2:0] ST_RST       = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_READY     = 3'd3;
  localparam logic [2:0] ST_FAIL      = 3'd4;

  // Terminal counts are "last value" so each counter compares against the
  // cycle on which the transition edge occurs.
  localparam logic [7:0]  RST_LAST  = 8'(RST_CYCLES - 1);
  localparam logic [15:0] TO_LAST   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [7:0]  STB_LAST  = 8'(STABLE_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

  logic        sync1_q;
  logic        locked_s_q;
  logic [2:0]  state_q,   state_d;
  logic [7:0]  rst_cnt_q, rst_cnt_d;
  logic [15:0] to_cnt_q,  to_cnt_d;
  logic [7:0]  stb_cnt_q, stb_cnt_d;
  logic [3:0]  retry_q,   retry_d;
  logic        lock_lost_q, lock_lost_d;
  logic        ppll_reset_q;
  logic        pll_ready_q;
  logic        pll_fail_q;

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    to_cnt_d    = to_cnt_q;
    stb_cnt_d   = stb_cnt_q;
    retry_d     = retry_q;
    lock_lost_d = lock_lost_q;
    case (state_q)
      ST_RST: begin
        to_cnt_d  = '0;
        stb_cnt_d = '0;
        if (rst_cnt_q == RST_LAST) begin
          rst_cnt_d = '0;
          state_d   = ST_WAIT_LOCK;
        end else begin
          rst_cnt_d = rst_cnt_q + 8'd1;
        end
      end
      ST_WAIT_LOCK: begin
        to_cnt_d = to_cnt_q + 16'd1;
        // Lock is tested first so it wins over a coincident timeout.
        if (locked_s_q) begin
          state_d   = ST_STABLE;
          stb_cnt_d = '0;
        // >= rather than ==: a lock won on the timeout edge leaves the
        // counter past TO_LAST, and a later return here must still time out.
        end else if (to_cnt_q >= TO_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 4'd1;
            state_d = ST_RST;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_STABLE: begin
        // Timeout counter is deliberately held, not cleared, on a glitch.
        if (!locked_s_q) begin
          state_d   = ST_WAIT_LOCK;
          stb_cnt_d = '0;
        end else if (stb_cnt_q == STB_LAST) begin
          state_d   = ST_READY;
          stb_cnt_d = '0;
          retry_d   = '0;
        end else begin
          stb_cnt_d = stb_cnt_q + 8'd1;
        end
      end
      ST_READY: begin
        if (!locked_s_q) begin
          lock_lost_d = 1'b1;
`ifdef CAE_PLL_CTL_AUTORELOCK_EN
          state_d = ST_RST;
          retry_d = '0;
`else
          state_d = ST_FAIL;
`endif
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      sync1_q      <= 1'b0;
      locked_s_q   <= 1'b0;
      state_q      <= ST_RST;
      rst_cnt_q    <= '0;
      to_cnt_q     <= '0;
      stb_cnt_q    <= '0;
      retry_q      <= '0;
      lock_lost_q  <= 1'b0;
      ppll_reset_q <= 1'b1;
      pll_ready_q  <= 1'b0;
      pll_fail_q   <= 1'b0;
    end else begin
      sync1_q      <= ppll_locked;
      locked_s_q   <= sync1_q;
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      to_cnt_q     <= to_cnt_d;
      stb_cnt_q    <= stb_cnt_d;
      retry_q      <= retry_d;
      lock_lost_q  <= lock_lost_d;
      // Outputs are decoded from the next state so they change on the same
      // edge as the state register, with no combinational path to ports.
      ppll_reset_q <= (state_d == ST_RST) || (state_d == ST_FAIL);
      pll_ready_q  <= (state_d == ST_READY);
      pll_fail_q   <= (state_d == ST_FAIL);
    end
  end

  assign ppll_reset  = ppll_reset_q;
  assign pll_ready   = pll_ready_q;
  assign pll_fail    = pll_fail_q;
  assign lock_lost   = lock_lost_q;
  assign retry_cnt   = retry_q;
  assign dbg_state_o = state_q;

endmodule
